// File: rtl/sm_prog_loader.sv
// Program loader: packs a little-endian byte stream into 32-bit words, writes them
// to instruction memory from address 0, and holds the CPU in reset while loading.
module sm_prog_loader #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  load_abort,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imWe,
  output logic [ADDR_WIDTH-1:0] imAddr,
  output logic [31:0]           imData,
  output logic                  cpu_rst_n,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] CNT_ZERO = {ADDR_WIDTH{1'b0}};

  state_e                  state_q, state_d;
  logic [1:0]              byte_cnt_q, byte_cnt_d;
  logic [ADDR_WIDTH-1:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [23:0]             word_q, word_d;
  logic                    rx_ready_q, rx_ready_d;
  logic                    imwe_q, imwe_d;
  logic [ADDR_WIDTH-1:0]   imaddr_q, imaddr_d;
  logic [31:0]             imdata_q, imdata_d;
  logic                    cpu_rst_n_q, cpu_rst_n_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic [31:0]             checksum_q, checksum_d;
  logic                    byte_accept;
  logic                    len_ok;
  logic [31:0]             full_word;

  assign byte_accept = rx_valid & rx_ready_q;
  assign len_ok      = (load_len != LEN_ZERO) && (load_len <= DEPTH);
  assign full_word   = {rx_data, word_q};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    imaddr_d   = imaddr_q;
    imdata_d   = imdata_q;
    err_d      = err_q;
    checksum_d = checksum_q;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          if (len_ok) begin
            err_d      = 1'b0;
            checksum_d = 32'd0;
            byte_cnt_d = 2'd0;
            word_cnt_d = CNT_ZERO;
            len_d      = load_len;
            state_d    = ST_RECV;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RECV: begin
        // Abort wins over a byte arriving in the same cycle; the partial word is dropped.
        if (load_abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (byte_accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = rx_data;
            2'd1:    word_d[15:8]  = rx_data;
            2'd2:    word_d[23:16] = rx_data;
            default: begin
              imdata_d   = full_word;
              imaddr_d   = word_cnt_q;
              checksum_d = checksum_q + full_word;
              state_d    = ST_WRITE;
            end
          endcase
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (load_abort) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (({1'b0, word_cnt_q} + LEN_ONE) == len_q) begin
          state_d = ST_DONE;
        end else begin
          word_cnt_d = word_cnt_q + CNT_ONE;
          state_d    = ST_RECV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    rx_ready_d  = (state_d == ST_RECV);
    imwe_d      = (state_d == ST_WRITE);
    busy_d      = (state_d != ST_IDLE);
    cpu_rst_n_d = (state_d == ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      word_cnt_q  <= CNT_ZERO;
      len_q       <= LEN_ZERO;
      word_q      <= 24'd0;
      rx_ready_q  <= 1'b0;
      imwe_q      <= 1'b0;
      imaddr_q    <= CNT_ZERO;
      imdata_q    <= 32'd0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= 32'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      rx_ready_q  <= rx_ready_d;
      imwe_q      <= imwe_d;
      imaddr_q    <= imaddr_d;
      imdata_q    <= imdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      checksum_q  <= checksum_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign imWe      = imwe_q;
  assign imAddr    = imaddr_q;
  assign imData    = imdata_q;
  assign cpu_rst_n = cpu_rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;

endmodule
